// File: rtl/controle_cronometro_pkg.sv
// Shared definitions for the stopwatch/timer keypad sequencer:
// key codes, mode encodings and the decimal accumulation step.
package controle_cronometro_pkg;

    localparam logic [3:0] TEC_MODO   = 4'hA;
    localparam logic [3:0] TEC_INICIA = 4'hB;
    localparam logic [3:0] TEC_ZERA   = 4'hC;
    localparam logic [3:0] TEC_CFG    = 4'hD;
    localparam logic [3:0] TEC_APAGA  = 4'hE;
    localparam logic [3:0] TEC_SALVA  = 4'hF;

    typedef enum logic [1:0] {
        CONFIG  = 2'd0,
        PRONTO  = 2'd1,
        RODANDO = 2'd2,
        PAUSADO = 2'd3
    } estado_t;

    // Appends one decimal digit: valor*10 + dig, done with shifts and adds.
    function automatic logic [15:0] acumula_digito(input logic [15:0] valor,
                                                   input logic [3:0]  dig);
        return (valor << 3) + (valor << 1) + {12'd0, dig};
    endfunction

endpackage

// File: rtl/controle_cronometro_if.sv
// Keypad inputs and counter control outputs of the sequencer.
// master = keypad/counter side, slave = the sequencer itself.
interface controle_cronometro_if;
    import controle_cronometro_pkg::*;

    logic        tecla_valida;
    logic [3:0]  tecla;
    logic        cfg;
    logic        sel;
    logic [15:0] tempo;
    logic        salve;
    logic        pause;
    logic        zera_tgl;
    estado_t     estado;

    modport master (
        output tecla_valida, tecla,
        input  cfg, sel, tempo, salve, pause, zera_tgl, estado
    );

    modport slave (
        input  tecla_valida, tecla,
        output cfg, sel, tempo, salve, pause, zera_tgl, estado
    );

endinterface

// File: rtl/controle_cronometro_detector_tecla.sv
// Rising-edge detector for the debounced key-held flag. A held key
// yields a single evento; the code is taken in that same cycle.
module detector_tecla
    import controle_cronometro_pkg::*;
(
    input  logic       clk,
    input  logic       reseta,
    input  logic       tecla_valida,
    input  logic [3:0] tecla,
    output logic       evento,
    output logic [3:0] codigo
);

    logic valida_ant;

    // Remember last cycle's key-held flag to find the press edge.
    always_ff @(posedge clk) begin
        if (reseta) begin
            valida_ant <= 1'b0;
        end else begin
            valida_ant <= tecla_valida;
        end
    end

    assign evento = tecla_valida & ~valida_ant;
    assign codigo = tecla;

endmodule

// File: rtl/controle_cronometro.sv
// Keypad-driven mode sequencer for the stopwatch/timer counter:
// turns key events into cfg/sel/tempo/salve/pause/zera_tgl and
// accumulates a typed decimal limit into a binary tempo value.
module controle_cronometro
    import controle_cronometro_pkg::*;
#(
    parameter int          MAX_DIG   = 4,
    parameter logic [15:0] TEMPO_INI = 16'd0
) (
    input  logic                 clk,
    input  logic                 reseta,
    controle_cronometro_if.slave bus
);

    localparam int NDIG_W = $clog2(MAX_DIG + 1);

    logic              evento;
    logic [3:0]        codigo;

    estado_t           estado_reg, estado_prox;
    logic              cfg_reg, cfg_prox;
    logic              sel_reg, sel_prox;
    logic [15:0]       tempo_reg, tempo_prox;
    logic              salve_reg, salve_prox;
    logic              pause_reg, pause_prox;
    logic              zera_reg, zera_prox;
    logic [NDIG_W-1:0] ndig_reg, ndig_prox;

    detector_tecla u_detector (
        .clk          (clk),
        .reseta       (reseta),
        .tecla_valida (bus.tecla_valida),
        .tecla        (bus.tecla),
        .evento       (evento),
        .codigo       (codigo)
    );

    // State and output registers; reset overrides any key event.
    always_ff @(posedge clk) begin
        if (reseta) begin
            estado_reg <= CONFIG;
            cfg_reg    <= 1'b1;
            sel_reg    <= 1'b0;
            tempo_reg  <= TEMPO_INI;
            salve_reg  <= 1'b0;
            pause_reg  <= 1'b1;
            zera_reg   <= 1'b0;
            ndig_reg   <= '0;
        end else begin
            estado_reg <= estado_prox;
            cfg_reg    <= cfg_prox;
            sel_reg    <= sel_prox;
            tempo_reg  <= tempo_prox;
            salve_reg  <= salve_prox;
            pause_reg  <= pause_prox;
            zera_reg   <= zera_prox;
            ndig_reg   <= ndig_prox;
        end
    end

    // Next-state and next-output decode for one key event.
    always_comb begin
        estado_prox = estado_reg;
        cfg_prox    = cfg_reg;
        sel_prox    = sel_reg;
        tempo_prox  = tempo_reg;
        salve_prox  = 1'b0;
        pause_prox  = pause_reg;
        zera_prox   = zera_reg;
        ndig_prox   = ndig_reg;

        if (evento) begin
            if (estado_reg == CONFIG) begin
                if (codigo <= 4'd9) begin
                    // Extra digits beyond MAX_DIG are dropped, bounding tempo to 9999.
                    if (ndig_reg < NDIG_W'(MAX_DIG)) begin
                        tempo_prox = acumula_digito(tempo_reg, codigo);
                        ndig_prox  = ndig_reg + NDIG_W'(1);
                    end
                end else begin
                    case (codigo)
                        TEC_APAGA: begin
                            tempo_prox = 16'd0;
                            ndig_prox  = '0;
                        end
                        TEC_MODO:  sel_prox = ~sel_reg;
                        TEC_SALVA: begin
                            cfg_prox    = 1'b0;
                            salve_prox  = 1'b1;
                            pause_prox  = 1'b1;
                            estado_prox = PRONTO;
                        end
                        default: ;
                    endcase
                end
            end else begin
                case (codigo)
                    TEC_INICIA: begin
                        if (estado_reg == RODANDO) begin
                            pause_prox  = 1'b1;
                            estado_prox = PAUSADO;
                        end else begin
                            pause_prox  = 1'b0;
                            estado_prox = RODANDO;
                        end
                    end
                    TEC_ZERA: begin
                        // A running count stops on zero; a paused one is already frozen.
                        zera_prox   = ~zera_reg;
                        pause_prox  = 1'b1;
                        estado_prox = PRONTO;
                    end
                    TEC_CFG: begin
                        cfg_prox    = 1'b1;
                        salve_prox  = 1'b1;
                        tempo_prox  = 16'd0;
                        ndig_prox   = '0;
                        pause_prox  = 1'b1;
                        estado_prox = CONFIG;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cfg      = cfg_reg;
    assign bus.sel      = sel_reg;
    assign bus.tempo    = tempo_reg;
    assign bus.salve    = salve_reg;
    assign bus.pause    = pause_reg;
    assign bus.zera_tgl = zera_reg;
    assign bus.estado   = estado_reg;

endmodule

// File: tb/tb_controle_cronometro.sv
// Bench for controle_cronometro: fixed key table from reset, hand-made
// hold/reset corner sequences, then random key traffic against an
// event-level model of the mode rules.
module tb_controle_cronometro;

    logic clk = 1'b0;
    logic reseta = 1'b0;
    int checks = 0;
    int errors = 0;

    controle_cronometro_if bus();

    controle_cronometro #(.MAX_DIG(4), .TEMPO_INI(16'd0)) dut (
        .clk    (clk),
        .reseta (reseta),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Model of the sequencer at key-event granularity.
    int m_tempo, m_ndig, m_est;
    bit m_cfg, m_sel, m_pause, m_zera, m_salve;

    typedef struct {
        logic [3:0] k;
        int         tempo;
        int         est;
        bit         cfg;
        bit         sel;
        bit         pause;
        bit         zera;
        bit         salve;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string tag, input string fld, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s actual=%0d required=%0d", tag, fld, act, req);
        end
    endtask

    task automatic model_reset();
        m_tempo = 0; m_ndig = 0; m_est = 0;
        m_cfg = 1; m_sel = 0; m_pause = 1; m_zera = 0; m_salve = 0;
    endtask

    task automatic model_enter_cfg();
        m_cfg = 1; m_salve = 1; m_tempo = 0; m_ndig = 0; m_pause = 1; m_est = 0;
    endtask

    task automatic model_key(input int k);
        m_salve = 0;
        if (m_est == 0) begin
            if (k <= 9) begin
                if (m_ndig < 4) begin
                    m_tempo = m_tempo * 10 + k;
                    m_ndig++;
                end
            end else if (k == 14) begin
                m_tempo = 0; m_ndig = 0;
            end else if (k == 10) begin
                m_sel = !m_sel;
            end else if (k == 15) begin
                m_cfg = 0; m_salve = 1; m_pause = 1; m_est = 1;
            end
        end else begin
            if (k == 13) begin
                model_enter_cfg();
            end else if (k == 11) begin
                if (m_est == 2) begin m_pause = 1; m_est = 3; end
                else begin m_pause = 0; m_est = 2; end
            end else if (k == 12) begin
                m_zera = !m_zera; m_pause = 1; m_est = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk(tag, "tempo",    int'(bus.tempo),    m_tempo);
        chk(tag, "estado",   int'(bus.estado),   m_est);
        chk(tag, "cfg",      int'(bus.cfg),      int'(m_cfg));
        chk(tag, "sel",      int'(bus.sel),      int'(m_sel));
        chk(tag, "pause",    int'(bus.pause),    int'(m_pause));
        chk(tag, "zera_tgl", int'(bus.zera_tgl), int'(m_zera));
        chk(tag, "salve",    int'(bus.salve),    int'(m_salve));
    endtask

    task automatic key_edge(input logic [3:0] k);
        @(negedge clk);
        bus.tecla_valida = 1'b1;
        bus.tecla = k;
        @(posedge clk);
        #1;
    endtask

    task automatic release_key();
        @(negedge clk);
        bus.tecla_valida = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Press, hold for 'hold' cycles (optionally scrambling the code), release.
    task automatic press(input string tag, input logic [3:0] k, input int hold, input bit scramble);
        key_edge(k);
        model_key(int'(k));
        check_model(tag);
        m_salve = 0;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (scramble) bus.tecla = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            check_model({tag, "_hold"});
        end
        release_key();
        check_model({tag, "_rel"});
    endtask

    task automatic do_reset(input string tag, input bit with_key);
        @(negedge clk);
        reseta = 1'b1;
        if (with_key) begin
            bus.tecla_valida = 1'b1;
            bus.tecla = 4'hB;
        end
        @(posedge clk);
        #1;
        model_reset();
        check_model(tag);
        @(negedge clk);
        reseta = 1'b0;
        bus.tecla_valida = 1'b0;
        @(posedge clk);
        #1;
        check_model({tag, "_post"});
    endtask

    initial begin
        bus.tecla_valida = 1'b0;
        bus.tecla = 4'h0;
        model_reset();

        //           k     tempo est cfg sel pause zera salve
        tab.push_back('{4'h1,    1, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'h2,   12, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'h3,  123, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'hF,  123, 1, 0, 0, 1, 0, 1});
        tab.push_back('{4'h7,  123, 1, 0, 0, 1, 0, 0});
        tab.push_back('{4'hD,    0, 0, 1, 0, 1, 0, 1});
        tab.push_back('{4'h9,    9, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'h8,   98, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'h7,  987, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'h6, 9876, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'h5, 9876, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'hC, 9876, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'hB, 9876, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'hE,    0, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'h4,    4, 0, 1, 0, 1, 0, 0});
        tab.push_back('{4'hA,    4, 0, 1, 1, 1, 0, 0});
        tab.push_back('{4'hF,    4, 1, 0, 1, 1, 0, 1});
        tab.push_back('{4'hA,    4, 1, 0, 1, 1, 0, 0});
        tab.push_back('{4'hD,    0, 0, 1, 1, 1, 0, 1});
        tab.push_back('{4'hF,    0, 1, 0, 1, 1, 0, 1});
        tab.push_back('{4'hB,    0, 2, 0, 1, 0, 0, 0});
        tab.push_back('{4'hB,    0, 3, 0, 1, 1, 0, 0});
        tab.push_back('{4'hC,    0, 1, 0, 1, 1, 1, 0});
        tab.push_back('{4'hC,    0, 1, 0, 1, 1, 0, 0});
        tab.push_back('{4'hB,    0, 2, 0, 1, 0, 0, 0});
        tab.push_back('{4'hC,    0, 1, 0, 1, 1, 1, 0});
        tab.push_back('{4'hB,    0, 2, 0, 1, 0, 1, 0});
        tab.push_back('{4'hD,    0, 0, 1, 1, 1, 1, 1});

        do_reset("reset", 1'b0);

        foreach (tab[i]) begin
            key_edge(tab[i].k);
            chk("tab", "tempo",    int'(bus.tempo),    tab[i].tempo);
            chk("tab", "estado",   int'(bus.estado),   tab[i].est);
            chk("tab", "cfg",      int'(bus.cfg),      int'(tab[i].cfg));
            chk("tab", "sel",      int'(bus.sel),      int'(tab[i].sel));
            chk("tab", "pause",    int'(bus.pause),    int'(tab[i].pause));
            chk("tab", "zera_tgl", int'(bus.zera_tgl), int'(tab[i].zera));
            chk("tab", "salve",    int'(bus.salve),    int'(tab[i].salve));
            model_key(int'(tab[i].k));
            release_key();
            chk("tab_next", "salve", int'(bus.salve), 0);
        end
        m_salve = 0;

        // Long hold of B in PRONTO, code switched to C mid-hold: one transition only.
        press("commit", 4'hF, 1, 1'b0);
        key_edge(4'hB);
        model_key(11);
        check_model("hold_b");
        m_salve = 0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (i >= 3) bus.tecla = 4'hC;
            @(posedge clk);
            #1;
            check_model("hold_b_held");
        end
        release_key();
        check_model("hold_b_rel");

        // Reset together with a key edge while running with tempo=42.
        do_reset("rst_pre", 1'b0);
        press("t4", 4'h4, 1, 1'b0);
        press("t2", 4'h2, 1, 1'b0);
        press("tF", 4'hF, 2, 1'b0);
        press("tB", 4'hB, 1, 1'b0);
        chk("run42", "tempo", int'(bus.tempo), 42);
        chk("run42", "estado", int'(bus.estado), 2);
        do_reset("rst_key", 1'b1);

        // Random key traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset("rnd_rst", 1'($urandom_range(0, 1)));
            end else begin
                logic [3:0] k;
                if ($urandom_range(0, 2) == 0) k = 4'($urandom_range(10, 15));
                else k = 4'($urandom_range(0, 15));
                press("rnd", k, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                check_model("rnd_idle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
